fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the control unit and datapath.
- Owns the PC, issues in-order requests to instruction memory, and buffers returned words in a small FIFO.
- Presents instruction/PC plus pre-sliced opcode/func3/func7 to decode.
- Consumes the pc_src/branch-target redirect produced downstream, flushing wrong-path work.

---
 rtl/rv32_pkg.sv | 20 ++
 rtl/fetch_unit_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch front end: widths, major opcodes and the buffered fetch entry.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous power-of-two FIFO with single-cycle flush; the head is shown combinationally and reads zero when empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_FULL) || do_pop);
    assign rdata_o = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Flush discards every stored entry but lets nothing new in during that cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers returned words and
// flushes wrong-path work on a branch redirect from the control unit.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count, tag_count;
    logic            fire, rsp_ok, keep, pop;
    logic [XLEN-1:0] rsp_pc;
    fetch_entry_t    push_entry, head;

    // Credit rule: buffered plus outstanding words never exceed the buffer, so every response has room.
    assign imem_req_valid = !rst && !redirect && (({1'b0, count} + {1'b0, inflight_q}) < CAP);
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (inflight_q != '0);
    assign keep           = rsp_ok && (drop_q == '0) && !redirect && !rst;
    assign pop            = out_valid && out_ready;
    assign push_entry     = '{pc: rsp_pc, instr: imem_rsp_data};

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_buf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (keep),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    // Only requests whose responses will be kept hold a tag, so a redirect can simply empty this queue.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (fire),
        .wdata_i (pc_q),
        .pop_i   (keep),
        .rdata_o (rsp_pc),
        .count_o (tag_count)
    );

    assign out_valid  = (count != '0);
    assign out_instr  = head.instr;
    assign out_pc     = head.pc;
    assign out_opcode = head.instr[6:0];
    assign out_func3  = head.instr[14:12];
    assign out_func7  = head.instr[31:25];

    // Stale requests stay counted as in flight until they return, keeping the credit rule exact;
    // drop marks how many of those returns are wrong-path.
    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q;
        if (fire) begin
            inflight_d = inflight_d + ONE;
        end
        if (rsp_ok) begin
            inflight_d = inflight_d - ONE;
        end
        if (rst) begin
            pc_d   = RESET_PC;
            drop_d = inflight_d;
        end else if (redirect) begin
            pc_d   = align_word(redirect_target);
            drop_d = inflight_d;
        end else begin
            if (fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q       <= pc_d;
        inflight_q <= inflight_d;
        drop_q     <= drop_d;
    end

    // Memory must not answer a request that was never issued; the tag queue tracks the kept requests.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (inflight_q == '0)));
            assert (tag_count == (inflight_q - drop_q));
        end
    end

endmodule
